// File: rtl/tlp_buffer_wr_arbiter_pkg.sv
// Shared widths and FSM encoding for the TLP buffer write path.
// Buffer_WIDTH is one buffer location; a write beat carries up to four locations.
package data_frag_package;

  localparam int Buffer_WIDTH    = 32;
  localparam int COUNT_WIDTH     = 9;
  localparam int NO_LOC_WR_WIDTH = 3;
  localparam int WR_DATA_WIDTH   = 4 * Buffer_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tlp_buffer_wr_arbiter_if.sv
// Write port between the arbiter and the TLP buffer.
// wr_en/data_in/no_loc_wr are a strobe, not a handshake; empty_loc is the buffer's free count,
// which reflects a write one cycle after wr_en.
interface buffer_frag_interface #(
  parameter int COUNT_WIDTH     = data_frag_package::COUNT_WIDTH,
  parameter int NO_LOC_WR_WIDTH = data_frag_package::NO_LOC_WR_WIDTH,
  parameter int WR_DATA_WIDTH   = data_frag_package::WR_DATA_WIDTH
) ();

  logic                       wr_en;
  logic [WR_DATA_WIDTH-1:0]   data_in;
  logic [NO_LOC_WR_WIDTH-1:0] no_loc_wr;
  logic [COUNT_WIDTH-1:0]     empty_loc;

  modport arbiter_buffer (
    output wr_en,
    output data_in,
    output no_loc_wr,
    input  empty_loc
  );

  modport buffer_arbiter (
    input  wr_en,
    input  data_in,
    input  no_loc_wr,
    output empty_loc
  );

endinterface

// File: rtl/tlp_buffer_wr_arbiter_rr_priority_picker.sv
// Round-robin picker: first asserted req at or after ptr, ascending with wrap-around.
// Outputs the winner one-hot and as an index; grant is zero when nothing is requested.
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    grant = '0;
    index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        index    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/tlp_buffer_wr_arbiter.sv
// Arbitrates TLP write beats from several sources into one buffer write port.
// A source keeps ownership from its first beat until its last beat; beats pass through combinationally.
module tlp_buffer_wr_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int COUNT_WIDTH     = data_frag_package::COUNT_WIDTH,
  parameter int NO_LOC_WR_WIDTH = data_frag_package::NO_LOC_WR_WIDTH,
  parameter int WR_DATA_WIDTH   = data_frag_package::WR_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic [NUM_REQ*NO_LOC_WR_WIDTH-1:0] req_no_loc,
  input  logic [NUM_REQ*WR_DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  buffer_frag_interface.arbiter_buffer       buf_if,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               busy
);

  import data_frag_package::arb_state_e;
  import data_frag_package::IDLE;
  import data_frag_package::LOCKED;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e                 r_state;
  logic [IDX_W-1:0]           r_rr_ptr;
  logic [IDX_W-1:0]           r_owner;

  logic [NUM_REQ-1:0]         w_pick_grant;
  logic [IDX_W-1:0]           w_pick_idx;
  logic [NUM_REQ-1:0]         w_owner_onehot;
  logic [IDX_W-1:0]           w_sel_idx;
  logic                       w_sel_valid;
  logic                       w_sel_last;
  logic [NO_LOC_WR_WIDTH-1:0] w_sel_no_loc;
  logic [WR_DATA_WIDTH-1:0]   w_sel_data;
  logic                       w_space_ok;
  logic                       w_accept;
  logic                       w_write;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_pick_grant),
    .index (w_pick_idx)
  );

  // While LOCKED only the owner is looked at, so other sources cannot slip a beat mid-TLP.
  always_comb begin
    w_owner_onehot          = '0;
    w_owner_onehot[r_owner] = 1'b1;
    w_sel_idx    = (r_state == LOCKED) ? r_owner : w_pick_idx;
    w_sel_valid  = (r_state == LOCKED) ? req_valid[r_owner] : (|w_pick_grant);
    w_sel_last   = req_last[w_sel_idx];
    w_sel_no_loc = req_no_loc[int'(w_sel_idx)*NO_LOC_WR_WIDTH +: NO_LOC_WR_WIDTH];
    w_sel_data   = req_data[int'(w_sel_idx)*WR_DATA_WIDTH +: WR_DATA_WIDTH];
    w_space_ok   = (COUNT_WIDTH'(w_sel_no_loc) <= buf_if.empty_loc);
    w_accept     = arst & w_sel_valid & w_space_ok;
    // An empty beat is still consumed, it just writes nothing.
    w_write      = w_accept & (w_sel_no_loc != '0);
  end

  assign req_ready        = w_accept ? ((r_state == LOCKED) ? w_owner_onehot : w_pick_grant) : '0;
  assign grant            = !arst ? '0 : ((r_state == LOCKED) ? w_owner_onehot : w_pick_grant);
  assign busy             = arst & (r_state == LOCKED);
  assign buf_if.wr_en     = w_write;
  assign buf_if.data_in   = w_write ? w_sel_data : '0;
  assign buf_if.no_loc_wr = w_write ? w_sel_no_loc : '0;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else if (w_accept) begin
      if (w_sel_last) begin
        r_state  <= IDLE;
        r_rr_ptr <= (int'(w_sel_idx) == NUM_REQ - 1) ? '0 : w_sel_idx + IDX_W'(1);
      end else if (r_state == IDLE) begin
        r_state <= LOCKED;
        r_owner <= w_sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_tlp_buffer_wr_arbiter.sv
// Directed bench for tlp_buffer_wr_arbiter: round robin, TLP locking, space stall,
// reset mid-TLP and zero-location beats, with hand-computed expectations.
module tb_tlp_buffer_wr_arbiter;

  logic         clk;
  logic         arst;
  logic [2:0]   req_valid;
  logic [2:0]   req_last;
  logic [8:0]   req_no_loc;
  logic [383:0] req_data;
  logic [2:0]   req_ready;
  logic [2:0]   grant;
  logic         busy;

  int total;
  int bad;

  buffer_frag_interface bif ();

  tlp_buffer_wr_arbiter dut (
    .clk        (clk),
    .arst       (arst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_no_loc (req_no_loc),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .buf_if     (bif.arbiter_buffer),
    .grant      (grant),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] src_data(input int s, input int b);
    return {32'hDA7A_0000 + 32'(s), 32'(b), 32'hCAFE_F00D, 32'(s * 16 + b)};
  endfunction

  task automatic set_src(input int s, input logic v, input logic l, input logic [2:0] n, input int b);
    req_valid[s]            = v;
    req_last[s]             = l;
    req_no_loc[s*3 +: 3]    = n;
    req_data[s*128 +: 128]  = src_data(s, b);
  endtask

  task automatic test_reset();
    arst          = 1'b0;
    bif.empty_loc = 9'd256;
    for (int k = 0; k < 3; k++) set_src(k, 1'b1, 1'b1, 3'd4, k);
    #2;
    total++; if (bif.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b exp 0", bif.wr_en); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready: got %b exp 000", req_ready); end
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL rst_grant: got %b exp 000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b exp 0", busy); end
    total++; if (bif.data_in !== 128'd0) begin bad++; $display("FAIL rst_data: got %h exp 0", bif.data_in); end
    total++; if (bif.no_loc_wr !== 3'd0) begin bad++; $display("FAIL rst_noloc: got %0d exp 0", bif.no_loc_wr); end
    @(negedge clk);
    req_valid = '0;
    arst      = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int         exp_s [4] = '{0, 1, 2, 0};
    @(negedge clk);
    bif.empty_loc = 9'd256;
    for (int k = 0; k < 3; k++) set_src(k, 1'b1, 1'b1, 3'd4, k);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (grant !== exp_g[c]) begin bad++; $display("FAIL rr_grant c%0d: got %b exp %b", c, grant, exp_g[c]); end
      total++; if (req_ready !== exp_g[c]) begin bad++; $display("FAIL rr_ready c%0d: got %b exp %b", c, req_ready, exp_g[c]); end
      total++; if (bif.wr_en !== 1'b1) begin bad++; $display("FAIL rr_wr_en c%0d: got %b exp 1", c, bif.wr_en); end
      total++; if (bif.no_loc_wr !== 3'd4) begin bad++; $display("FAIL rr_noloc c%0d: got %0d exp 4", c, bif.no_loc_wr); end
      total++; if (bif.data_in !== src_data(exp_s[c], exp_s[c])) begin bad++; $display("FAIL rr_data c%0d: got %h exp %h", c, bif.data_in, src_data(exp_s[c], exp_s[c])); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_busy c%0d: got %b exp 0", c, busy); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  // rr_ptr is 1 on entry: source 1 wins, holds through a gap, then 2 and 0 follow.
  task automatic test_locked_tlp();
    logic       s1_v  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       s1_l  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int         s1_b  [6] = '{0, 1, 1, 2, 2, 2};
    logic [2:0] exp_g [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    logic [2:0] exp_r [6] = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b100, 3'b001};
    logic       exp_w [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_b [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int         exp_s [6] = '{1, 1, 1, 1, 2, 0};
    logic [127:0] e_data;
    logic [2:0]   e_nl;
    @(negedge clk);
    bif.empty_loc = 9'd256;
    set_src(0, 1'b1, 1'b1, 3'd1, 0);
    set_src(2, 1'b1, 1'b1, 3'd1, 0);
    for (int c = 0; c < 6; c++) begin
      set_src(1, s1_v[c], s1_l[c], 3'd2, s1_b[c]);
      e_data = !exp_w[c] ? 128'd0 : (exp_s[c] == 1) ? src_data(1, s1_b[c]) : src_data(exp_s[c], 0);
      e_nl   = !exp_w[c] ? 3'd0 : (exp_s[c] == 1) ? 3'd2 : 3'd1;
      #1;
      total++; if (grant !== exp_g[c]) begin bad++; $display("FAIL lock_grant c%0d: got %b exp %b", c, grant, exp_g[c]); end
      total++; if (req_ready !== exp_r[c]) begin bad++; $display("FAIL lock_ready c%0d: got %b exp %b", c, req_ready, exp_r[c]); end
      total++; if (bif.wr_en !== exp_w[c]) begin bad++; $display("FAIL lock_wr_en c%0d: got %b exp %b", c, bif.wr_en, exp_w[c]); end
      total++; if (busy !== exp_b[c]) begin bad++; $display("FAIL lock_busy c%0d: got %b exp %b", c, busy, exp_b[c]); end
      total++; if (bif.data_in !== e_data) begin bad++; $display("FAIL lock_data c%0d: got %h exp %h", c, bif.data_in, e_data); end
      total++; if (bif.no_loc_wr !== e_nl) begin bad++; $display("FAIL lock_noloc c%0d: got %0d exp %0d", c, bif.no_loc_wr, e_nl); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  // rr_ptr is 1 on entry; only source 1 requests a 3-location beat.
  task automatic test_space_stall();
    logic [8:0] el    [6] = '{9'd2, 9'd2, 9'd3, 9'd2, 9'd3, 9'd256};
    logic       v     [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       l     [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] exp_g [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    logic [2:0] exp_r [6] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
    logic       exp_w [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_b [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] e_nl;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      bif.empty_loc = el[c];
      set_src(1, v[c], l[c], 3'd3, c);
      e_nl = exp_w[c] ? 3'd3 : 3'd0;
      #1;
      total++; if (grant !== exp_g[c]) begin bad++; $display("FAIL stall_grant c%0d: got %b exp %b", c, grant, exp_g[c]); end
      total++; if (req_ready !== exp_r[c]) begin bad++; $display("FAIL stall_ready c%0d: got %b exp %b", c, req_ready, exp_r[c]); end
      total++; if (bif.wr_en !== exp_w[c]) begin bad++; $display("FAIL stall_wr_en c%0d: got %b exp %b", c, bif.wr_en, exp_w[c]); end
      total++; if (busy !== exp_b[c]) begin bad++; $display("FAIL stall_busy c%0d: got %b exp %b", c, busy, exp_b[c]); end
      total++; if (bif.no_loc_wr !== e_nl) begin bad++; $display("FAIL stall_noloc c%0d: got %0d exp %0d", c, bif.no_loc_wr, e_nl); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  // rr_ptr is 2 on entry: source 2 starts a 4-beat TLP, reset hits on its second beat.
  task automatic test_reset_mid_tlp();
    @(negedge clk);
    bif.empty_loc = 9'd256;
    set_src(0, 1'b1, 1'b1, 3'd1, 5);
    set_src(1, 1'b1, 1'b1, 3'd1, 5);
    set_src(2, 1'b1, 1'b0, 3'd1, 0);
    #1;
    total++; if (grant !== 3'b100) begin bad++; $display("FAIL mid_first_grant: got %b exp 100", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_first_busy: got %b exp 0", busy); end
    @(negedge clk);
    set_src(2, 1'b1, 1'b0, 3'd1, 1);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_locked_busy: got %b exp 1", busy); end
    arst = 1'b0;
    #1;
    total++; if (bif.wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr_en: got %b exp 0", bif.wr_en); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL mid_rst_ready: got %b exp 000", req_ready); end
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL mid_rst_grant: got %b exp 000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b exp 0", busy); end
    total++; if (bif.data_in !== 128'd0) begin bad++; $display("FAIL mid_rst_data: got %h exp 0", bif.data_in); end
    total++; if (bif.no_loc_wr !== 3'd0) begin bad++; $display("FAIL mid_rst_noloc: got %0d exp 0", bif.no_loc_wr); end
    @(negedge clk);
    arst = 1'b1;
    #1;
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL mid_after_grant: got %b exp 001", grant); end
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_after_ready: got %b exp 001", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_after_busy: got %b exp 0", busy); end
    total++; if (bif.data_in !== src_data(0, 5)) begin bad++; $display("FAIL mid_after_data: got %h exp %h", bif.data_in, src_data(0, 5)); end
    @(negedge clk);
    req_valid = '0;
  endtask

  // rr_ptr is 1 on entry; source 2 sends an empty last beat with no free space.
  task automatic test_zero_loc();
    @(negedge clk);
    bif.empty_loc = 9'd0;
    set_src(2, 1'b1, 1'b1, 3'd0, 7);
    #1;
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL zero_ready: got %b exp 100", req_ready); end
    total++; if (bif.wr_en !== 1'b0) begin bad++; $display("FAIL zero_wr_en: got %b exp 0", bif.wr_en); end
    total++; if (grant !== 3'b100) begin bad++; $display("FAIL zero_grant: got %b exp 100", grant); end
    total++; if (bif.data_in !== 128'd0) begin bad++; $display("FAIL zero_data: got %h exp 0", bif.data_in); end
    total++; if (bif.no_loc_wr !== 3'd0) begin bad++; $display("FAIL zero_noloc: got %0d exp 0", bif.no_loc_wr); end
    @(negedge clk);
    bif.empty_loc = 9'd256;
    for (int k = 0; k < 3; k++) set_src(k, 1'b1, 1'b1, 3'd1, k);
    #1;
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL zero_ptr_grant: got %b exp 001", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_ptr_busy: got %b exp 0", busy); end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    arst          = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    req_no_loc    = '0;
    req_data      = '0;
    bif.empty_loc = '0;
    test_reset();
    test_round_robin();
    test_locked_tlp();
    test_space_stall();
    test_reset_mid_tlp();
    test_zero_loc();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
